// File: rtl/cpu_wb_add_seq.sv
// Valid/ready sequencing stage in front of a parallel-prefix carry look-ahead adder.
// Define CPU_WB_ADD_OVF_EN to add the registered signed-overflow output m_ovf_o.

module cpu_wb_add_cla #(
  parameter int unsigned DATA_WID = 32
) (
  input  logic [DATA_WID-1:0] a_i,
  input  logic [DATA_WID-1:0] b_i,
  input  logic                cin_i,
  output logic [DATA_WID-1:0] sum_o,
  output logic                cout_o
);

  logic [DATA_WID-1:0] gen;
  logic [DATA_WID-1:0] prop;
  logic [DATA_WID-1:0] grp_g;
  logic [DATA_WID-1:0] grp_p;
  logic [DATA_WID-1:0] prev_g;
  logic [DATA_WID-1:0] prev_p;
  logic [DATA_WID-1:0] carry;

  // Carry-in is folded into bit 0's generate, so each grp_g[i] is the carry out of bit i.
  always_comb begin
    gen      = a_i & b_i;
    prop     = a_i ^ b_i;
    grp_g    = gen;
    grp_g[0] = gen[0] | (prop[0] & cin_i);
    grp_p    = prop;
    prev_g   = '0;
    prev_p   = '0;
    for (int unsigned d = 1; d < DATA_WID; d = d * 2) begin
      prev_g = grp_g;
      prev_p = grp_p;
      for (int unsigned i = d; i < DATA_WID; i++) begin
        grp_g[i] = prev_g[i] | (prev_p[i] & prev_g[i-d]);
        grp_p[i] = prev_p[i] & prev_p[i-d];
      end
    end
    carry  = {grp_g[DATA_WID-2:0], cin_i};
    sum_o  = prop ^ carry;
    cout_o = grp_g[DATA_WID-1];
  end

endmodule

module cpu_wb_add_seq #(
  parameter int unsigned DATA_WID = 32,
  parameter int unsigned IDX_WID  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [DATA_WID-1:0] s_in1_i,
  input  logic [DATA_WID-1:0] s_in2_i,
  input  logic                s_cin_i,
  input  logic                s_sub_i,
  input  logic                s_first_i,
  input  logic                s_last_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [DATA_WID-1:0] m_sum_o,
  output logic                m_cout_o,
  output logic                m_last_o,
  output logic [IDX_WID-1:0]  m_idx_o,
`ifdef CPU_WB_ADD_OVF_EN
  output logic                m_ovf_o,
`endif
  output logic                err_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHAIN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                carry_q, carry_d;
  logic                sub_q, sub_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic [DATA_WID-1:0] sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                last_q, last_d;
  logic [IDX_WID-1:0]  idx_q, idx_d;

  logic                acc;
  logic                beat_first;
  logic                beat_sub;
  logic                add_cin;
  logic [DATA_WID-1:0] add_b;
  logic [DATA_WID-1:0] add_sum;
  logic                add_cout;

  assign s_ready_o = ~valid_q | m_ready_i;
  assign acc       = s_valid_i & s_ready_o;

  // A beat in IDLE is always treated as first, whatever s_first_i says.
  assign beat_first = s_first_i | (state_q == ST_IDLE);
  assign beat_sub   = beat_first ? s_sub_i : sub_q;
  assign add_cin    = beat_first ? (s_cin_i ^ s_sub_i) : carry_q;
  assign add_b      = s_in2_i ^ {DATA_WID{beat_sub}};

  cpu_wb_add_cla #(
    .DATA_WID(DATA_WID)
  ) u_cla (
    .a_i   (s_in1_i),
    .b_i   (add_b),
    .cin_i (add_cin),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    err_d   = err_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    last_d  = last_q;
    idx_d   = idx_q;

    if (acc) begin
      state_d = s_last_i ? ST_IDLE : ST_CHAIN;
      carry_d = add_cout;
      sub_d   = beat_sub;
      valid_d = 1'b1;
      sum_d   = add_sum;
      cout_d  = add_cout;
      last_d  = s_last_i;
      idx_d   = beat_first ? '0 : idx_q + IDX_WID'(1);
      if (((state_q == ST_IDLE) && !s_first_i) || ((state_q == ST_CHAIN) && s_first_i)) begin
        err_d = 1'b1;
      end
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

`ifdef CPU_WB_ADD_OVF_EN
  logic ovf_q;
  logic carry_into_msb;

  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign carry_into_msb = add_sum[DATA_WID-1] ^ s_in1_i[DATA_WID-1] ^ add_b[DATA_WID-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (acc) begin
      ovf_q <= carry_into_msb ^ add_cout;
    end
  end

  assign m_ovf_o = ovf_q;
`endif

  assign m_valid_o = valid_q;
  assign m_sum_o   = sum_q;
  assign m_cout_o  = cout_q;
  assign m_last_o  = last_q;
  assign m_idx_o   = idx_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_cpu_wb_add_seq.sv
// Directed bench for cpu_wb_add_seq: vector table plus hand-written back-pressure,
// protocol-error, reset and index-wrap sequences (overflow checks when CPU_WB_ADD_OVF_EN).

module tb_cpu_wb_add_seq;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_in1;
  logic [31:0] s_in2;
  logic        s_cin;
  logic        s_sub;
  logic        s_first;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_sum;
  logic        m_cout;
  logic        m_last;
  logic [3:0]  m_idx;
  logic        err;
`ifdef CPU_WB_ADD_OVF_EN
  logic        m_ovf;
`endif

  int checks;
  int failures;

  cpu_wb_add_seq #(
    .DATA_WID(32),
    .IDX_WID (4)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .s_in1_i  (s_in1),
    .s_in2_i  (s_in2),
    .s_cin_i  (s_cin),
    .s_sub_i  (s_sub),
    .s_first_i(s_first),
    .s_last_i (s_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .m_sum_o  (m_sum),
    .m_cout_o (m_cout),
    .m_last_o (m_last),
    .m_idx_o  (m_idx),
`ifdef CPU_WB_ADD_OVF_EN
    .m_ovf_o  (m_ovf),
`endif
    .err_o    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        first;
    logic        last;
    logic [31:0] sum;
    logic        cout;
    logic [3:0]  idx;
  } vec_t;

  localparam int NVEC = 10;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_beat(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic first, input logic last);
    s_valid = 1'b1;
    s_in1   = a;
    s_in2   = b;
    s_cin   = cin;
    s_sub   = sub;
    s_first = first;
    s_last  = last;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_beat;
    s_valid = 1'b0;
    tick();
  endtask

  logic [31:0] held_sum;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    s_valid  = 1'b0;
    m_ready  = 1'b1;
    s_in1    = '0;
    s_in2    = '0;
    s_cin    = 1'b0;
    s_sub    = 1'b0;
    s_first  = 1'b0;
    s_last   = 1'b0;

    //            a             b             cin   sub   first last  sum           cout  idx
    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 4'd0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 4'd0};
    tbl[2] = '{32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 4'd1};
    tbl[3] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'd0};
    tbl[4] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 4'd1};
    tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2345_678A, 1'b0, 4'd0};
    tbl[6] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 4'd0};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 4'd0};
    tbl[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 4'd1};
    tbl[9] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'd2};

    do_reset();
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_sum",   m_sum, 32'd0);
    chk("rst_cout",  {31'd0, m_cout}, 32'd0);
    chk("rst_last",  {31'd0, m_last}, 32'd0);
    chk("rst_idx",   {28'd0, m_idx}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, s_ready}, 32'd1);

    // Back-to-back beats with downstream always ready.
    for (int i = 0; i < NVEC; i++) begin
      set_beat(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].first, tbl[i].last);
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, m_valid}, 32'd1);
      chk($sformatf("v%0d_sum", i),   m_sum, tbl[i].sum);
      chk($sformatf("v%0d_cout", i),  {31'd0, m_cout}, {31'd0, tbl[i].cout});
      chk($sformatf("v%0d_last", i),  {31'd0, m_last}, {31'd0, tbl[i].last});
      chk($sformatf("v%0d_idx", i),   {28'd0, m_idx}, {28'd0, tbl[i].idx});
      chk($sformatf("v%0d_err", i),   {31'd0, err}, 32'd0);
    end
    idle_beat();
    chk("drain_valid", {31'd0, m_valid}, 32'd0);

    // Back-pressure: result held, input stalled, then retire+load on the same edge.
    set_beat(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 1'b1);
    m_ready = 1'b0;
    tick();
    held_sum = 32'h0000_0030;
    set_beat(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_ready", c), {31'd0, s_ready}, 32'd0);
      chk($sformatf("bp%0d_valid", c), {31'd0, m_valid}, 32'd1);
      chk($sformatf("bp%0d_sum", c),   m_sum, held_sum);
      tick();
    end
    m_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {31'd0, s_ready}, 32'd1);
    tick();
    chk("bp_load_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_load_sum",   m_sum, 32'h0000_0300);
    idle_beat();
    chk("bp_retire_valid", {31'd0, m_valid}, 32'd0);

    // Non-first beat after reset: flagged, uses s_cin_i.
    do_reset();
    set_beat(32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("pe1_err", {31'd0, err}, 32'd1);
    chk("pe1_sum", m_sum, 32'h0000_000C);
    chk("pe1_idx", {28'd0, m_idx}, 32'd0);
    set_beat(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("pe1_sticky", {31'd0, err}, 32'd1);
    chk("pe1_next_sum", m_sum, 32'h0000_0002);

    // First beat mid-chain restarts and discards chained carry.
    do_reset();
    set_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pe2_pre_err", {31'd0, err}, 32'd0);
    set_beat(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("pe2_err", {31'd0, err}, 32'd1);
    chk("pe2_sum", m_sum, 32'h0000_0000);
    chk("pe2_idx", {28'd0, m_idx}, 32'd0);

    // Reset mid-chain: new first beat sees no chained carry.
    do_reset();
    set_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    do_reset();
    set_beat(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("rmc_sum",  m_sum, 32'h0000_0000);
    chk("rmc_cout", {31'd0, m_cout}, 32'd0);
    chk("rmc_idx",  {28'd0, m_idx}, 32'd0);
    chk("rmc_err",  {31'd0, err}, 32'd0);

    // 17-beat chain: index wraps modulo 16.
    for (int i = 0; i < 17; i++) begin
      set_beat(32'd0, 32'd0, 1'b0, 1'b0, (i == 0), (i == 16));
      tick();
      chk($sformatf("wrap%0d_idx", i), {28'd0, m_idx}, 32'(i % 16));
    end
    chk("wrap_last", {31'd0, m_last}, 32'd1);
    chk("wrap_err",  {31'd0, err}, 32'd0);
    idle_beat();

`ifdef CPU_WB_ADD_OVF_EN
    do_reset();
    chk("ovf_rst", {31'd0, m_ovf}, 32'd0);
    set_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("ovf1_sum", m_sum, 32'h8000_0000);
    chk("ovf1_ovf", {31'd0, m_ovf}, 32'd1);
    set_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("ovf2_sum", m_sum, 32'h0000_0000);
    chk("ovf2_ovf", {31'd0, m_ovf}, 32'd0);
    set_beat(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("ovf3_sum", m_sum, 32'h7FFF_FFFF);
    chk("ovf3_ovf", {31'd0, m_ovf}, 32'd1);
    idle_beat();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_wb_add_seq.md
# cpu_wb_add_seq

Valid/ready sequencing stage that sits directly upstream of the 32-bit carry look-ahead adder and registers its result. It accepts operand beats, forms the adder's carry-in (external, subtract-forced, or chained from the previous beat), and presents a registered sum/carry beat downstream. Multi-word additions and subtractions (e.g. 64/128-bit) stream through as consecutive beats.

## Interface
- DATA_WID, 32: operand/sum width per beat; passed to the adder instance.
- IDX_WID, 4: width of the beat-index counter.
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- s_valid_i  in  1  operand beat valid.
- s_ready_o  out  1  stage can accept a beat.
- s_in1_i  in  DATA_WID  operand A.
- s_in2_i  in  DATA_WID  operand B.
- s_cin_i  in  1  external carry-in; used on the first beat only.
- s_sub_i  in  1  subtract A-B; sampled on the first beat, held for the operation.
- s_first_i  in  1  beat starts a new operation.
- s_last_i  in  1  beat ends the operation.
- m_valid_o  out  1  result beat valid.
- m_ready_i  in  1  downstream accepts the result.
- m_sum_o  out  DATA_WID  registered sum.
- m_cout_o  out  1  registered carry-out of this beat.
- m_last_o  out  1  registered copy of s_last_i.
- m_idx_o  out  IDX_WID  beat index within the operation, 0 on the first beat.
- err_o  out  1  sticky protocol-error flag.

## Operation
- Accept condition: `acc = s_valid_i & s_ready_o`. `s_ready_o = ~m_valid_o | m_ready_i` (single output register, no bubble when downstream is ready).
- State machine:
  - IDLE: expecting a first beat.
  - CHAIN: mid-operation.
  - IDLE→CHAIN on an accepted beat with `s_last_i=0`. CHAIN→IDLE on an accepted beat with `s_last_i=1`. A first+last beat stays in IDLE.
- Operand B to the adder: `s_in2_i ^ {DATA_WID{sub}}`. `sub` is `s_sub_i` on a first beat, otherwise the latched `sub_q`.
- Adder carry-in:
  - First beat: `s_cin_i ^ s_sub_i`. For subtraction, `s_cin_i=0` means no borrow-in.
  - Chained beat: `carry_q`, the adder carry-out of the previous accepted beat.
- Every accept updates `carry_q`, `sub_q` and the index counter. The index resets to 0 on a first beat, otherwise increments and wraps modulo 2^IDX_WID.
- Protocol errors: each sets `err_o` and the beat is still processed.
  - In IDLE, a beat with `s_first_i=0` is treated as a first beat.
  - In CHAIN, a beat with `s_first_i=1` restarts the operation: chained carry is discarded and the beat is treated as first.
- `err_o` clears only on reset.
- Output register loads `{sum, cout, last, idx}` on `acc`. `m_valid_o` sets on `acc`, and clears when `m_ready_i & ~acc`.

## Timing
- Latency: exactly 1 cycle from accept to `m_valid_o`.
- Throughput: 1 beat/cycle while `m_ready_i=1`.
- Back-pressure: while `m_valid_o & ~m_ready_i`, `s_ready_o=0` and all `m_*` outputs hold stable.
- Simultaneous `m_ready_i` and `acc`: the old result retires and the new one loads in the same edge; `m_valid_o` stays 1.
- The combinational path from `m_ready_i` to `s_ready_o` is allowed.
- Reset values: `m_valid_o=0`, `m_sum_o=0`, `m_cout_o=0`, `m_last_o=0`, `m_idx_o=0`, `err_o=0`; state IDLE; `carry_q=0`, `sub_q=0`.
- `s_ready_o=1` during the cycle after reset.
- Reset asserted mid-operation abandons it: the next beat must carry `s_first_i`, otherwise `err_o` sets.

## Configuration
- `CPU_WB_ADD_OVF_EN` defined:
  - Adds output port `m_ovf_o` (1 bit), registered with the result.
  - Value is signed overflow of the beat: `carry into MSB ^ carry out of MSB`. It is meaningful on the last beat.
  - Reset value 0.
- Macro undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Single-beat add: A=0xFFFF_FFFF, B=0x1, cin=0, first=last=1 → next cycle `m_sum_o=0`, `m_cout_o=1`, `m_idx_o=0`, `m_last_o=1`.
- 64-bit add in 2 beats: A=0x0000_0001_FFFF_FFFF, B=0x1 → beat0 sum=0, cout=1; beat1 sum=0x2, cout=0, idx=1, last=1.
- 64-bit subtract: 0x1_0000_0000 − 1, sub=1, cin=0 → beat0 sum=0xFFFF_FFFF, cout=0; beat1 sum=0, cout=1 (no borrow).
- Back-pressure: hold `m_ready_i=0` for 3 cycles after a result → `s_ready_o=0`, outputs stable. Then `m_ready_i=1` with a new beat valid → retire and load on the same edge, no bubble.
- Protocol error:
  - Beat with first=0 after reset → `err_o=1`, processed with cin from `s_cin_i`.
  - Reset mid-chain, then first beat → `carry_q` not used, `m_idx_o=0`.
- With `CPU_WB_ADD_OVF_EN`: 0x7FFF_FFFF + 1, first=last=1 → `m_ovf_o=1`, `m_sum_o=0x8000_0000`. Then 0xFFFF_FFFF + 1 → `m_ovf_o=0`.
